// File: rtl/button_pkg.sv
// Shared types, default timing and counter sizing for the button conditioner.
package button_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PRESS_DB = 2'd1,
      S_HELD     = 2'd2,
      S_REL_DB   = 2'd3
   } btn_state_t;

   localparam int unsigned DEF_N_CH            = 4;
   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
   localparam int unsigned DEF_REPEAT_DELAY    = 5000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 1000000;

   // Bits needed to hold the largest of the three timing values.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: input synchroniser, debounce FSM, registered press/release/repeat pulses.
module button_channel
   import button_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic Clk,
   input  logic Resetn,
   input  logic Bi,
   input  logic RepeatEn,
   output logic Press,
   output logic Rpt,
   output logic Release,
   output logic Level
);

   localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   bs;
   btn_state_t             state_q, state_d;
   logic [CW-1:0]          db_cnt_q, db_cnt_d;
   logic [CW-1:0]          rp_cnt_q, rp_cnt_d;
   logic                   rp_phase_q, rp_phase_d;
   logic                   press_d, rpt_d, rel_d, level_d;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   assign bs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= Bi;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      rp_cnt_d   = rp_cnt_q;
      rp_phase_d = rp_phase_q;
      press_d    = 1'b0;
      rpt_d      = 1'b0;
      rel_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            db_cnt_d   = '0;
            rp_cnt_d   = '0;
            rp_phase_d = 1'b0;
            if (bs) begin
               db_cnt_d = CW'(1);
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = S_HELD;
                  press_d = 1'b1;
               end else begin
                  state_d = S_PRESS_DB;
               end
            end
         end
         S_PRESS_DB: begin
            if (!bs) begin
               state_d  = S_IDLE;
               db_cnt_d = '0;
            end else if (db_cnt_q >= DB_LAST) begin
               state_d    = S_HELD;
               press_d    = 1'b1;
               rp_cnt_d   = '0;
               rp_phase_d = 1'b0;
            end else begin
               db_cnt_d = sat_inc(db_cnt_q);
            end
         end
         S_HELD: begin
            // Repeat counting only on edges that stay held, so Rpt cannot share an edge with Release.
            if (!bs) begin
               db_cnt_d = CW'(1);
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = S_IDLE;
                  rel_d   = 1'b1;
               end else begin
                  state_d = S_REL_DB;
               end
            end else if (RepeatEn) begin
               if (rp_cnt_q >= (rp_phase_q ? PER_LAST : DLY_LAST)) begin
                  rpt_d      = 1'b1;
                  rp_cnt_d   = '0;
                  rp_phase_d = 1'b1;
               end else begin
                  rp_cnt_d = sat_inc(rp_cnt_q);
               end
            end
         end
         S_REL_DB: begin
            if (bs) begin
               state_d = S_HELD;
            end else if (db_cnt_q >= DB_LAST) begin
               state_d = S_IDLE;
               rel_d   = 1'b1;
            end else begin
               db_cnt_d = sat_inc(db_cnt_q);
            end
         end
         default: begin
            state_d    = S_IDLE;
            db_cnt_d   = '0;
            rp_cnt_d   = '0;
            rp_phase_d = 1'b0;
         end
      endcase
      if (!RepeatEn) begin
         rp_cnt_d   = '0;
         rp_phase_d = 1'b0;
      end
      level_d = (state_d == S_HELD) || (state_d == S_REL_DB);
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_IDLE;
         db_cnt_q   <= '0;
         rp_cnt_q   <= '0;
         rp_phase_q <= 1'b0;
         Press      <= 1'b0;
         Rpt        <= 1'b0;
         Release    <= 1'b0;
         Level      <= 1'b0;
      end else begin
         state_q    <= state_d;
         db_cnt_q   <= db_cnt_d;
         rp_cnt_q   <= rp_cnt_d;
         rp_phase_q <= rp_phase_d;
         Press      <= press_d;
         Rpt        <= rpt_d;
         Release    <= rel_d;
         Level      <= level_d;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: one independent button_channel per input bit.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned N_CH            = DEF_N_CH,
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic            Clk,
   input  logic            Resetn,
   input  logic [N_CH-1:0] Bis,
   input  logic [N_CH-1:0] RepeatEn,
   output logic [N_CH-1:0] Press,
   output logic [N_CH-1:0] Rpt,
   output logic [N_CH-1:0] Release,
   output logic [N_CH-1:0] Level
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      button_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .Clk     (Clk),
         .Resetn  (Resetn),
         .Bi      (Bis[i]),
         .RepeatEn(RepeatEn[i]),
         .Press   (Press[i]),
         .Rpt     (Rpt[i]),
         .Release (Release[i]),
         .Level   (Level[i])
      );
   end

endmodule
